spi_xfer_ctrl: RTL and testbench

Transaction sequencer for the SPI general module's 12-bit data register. On a start pulse it captures the register's low DATA_W bits and shifts them out MSB-first as an SPI mode-0 master, with an `sclk` rate set by a programmable divider. It then writes the received word back through the register's priority write port (IN2/WR2). It also provides `busy` and `done` so the CPU-side write port (WR1) can be gated during a transfer.

---
 rtl/spi_xfer_ctrl_pkg.sv | 8 +
 rtl/spi_xfer_ctrl_if.sv | 28 ++
 rtl/spi_clk_div.sv | 19 +
 rtl/spi_xfer_ctrl.sv | 112 +++++++++++
 tb/tb_spi_xfer_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared types and constants for the SPI transfer sequencer.
package spi_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, WRITEBACK} state_t;

  localparam int DATA_W_DEF = 12;
  localparam int DIV_W_DEF  = 8;
  localparam int REG_W      = 32;
endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// CPU/register-side and serial-side signals of the SPI transfer sequencer.
interface spi_xfer_ctrl_if #(
  parameter int DIV_W = spi_ctrl_pkg::DIV_W_DEF
);
  import spi_ctrl_pkg::*;

  logic             start;
  logic [DIV_W-1:0] div;
  logic [REG_W-1:0] tx_data;
  logic             miso;
  logic             sclk;
  logic             cs_n;
  logic             mosi;
  logic [REG_W-1:0] rx_data;
  logic             rx_wr;
  logic             busy;
  logic             done;

  modport master (
    output start, div, tx_data, miso,
    input  sclk, cs_n, mosi, rx_data, rx_wr, busy, done
  );

  modport slave (
    input  start, div, tx_data, miso,
    output sclk, cs_n, mosi, rx_data, rx_wr, busy, done
  );
endinterface

// File: rtl/spi_clk_div.sv
// Half-period counter: counts 0..div while enabled and flags the wrap cycle.
module spi_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == div);

  always_ff @(posedge clk) begin
    if (rst || !en || tick) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 master sequencer: shifts the data register out MSB-first and
// writes the received word back through the priority write port.
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input logic            clk,
  input logic            rst,
  spi_xfer_ctrl_if.slave bus
);
  localparam int BCW = $clog2(DATA_W + 1);

  state_t           state;
  logic [DIV_W-1:0] div_q;
  logic [DATA_W-1:0] tx_sr, rx_sr, tx_nxt, rx_nxt;
  logic [BCW-1:0]   bit_cnt;
  logic             tick, cnt_en;
  logic             sclk_q, cs_n_q, mosi_q, rx_wr_q, busy_q, done_q;
  logic [REG_W-1:0] rx_data_q;
  logic             unused_tx_hi;

  // Bits above DATA_W belong to the register but are not transmitted.
  assign unused_tx_hi = |(bus.tx_data >> DATA_W);

  assign cnt_en = (state == SETUP) || (state == SHIFT) || (state == HOLD);
  assign tx_nxt = tx_sr << 1;
  assign rx_nxt = (rx_sr << 1) | DATA_W'(bus.miso);

  spi_clk_div #(.DIV_W(DIV_W)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .div  (div_q),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_q     <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      rx_data_q <= '0;
      rx_wr_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rx_wr_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state)
        IDLE: if (bus.start) begin
          state   <= SETUP;
          div_q   <= bus.div;
          tx_sr   <= bus.tx_data[DATA_W-1:0];
          rx_sr   <= '0;
          bit_cnt <= '0;
          cs_n_q  <= 1'b0;
          busy_q  <= 1'b1;
          mosi_q  <= bus.tx_data[DATA_W-1];
        end
        SETUP: if (tick) begin
          state  <= SHIFT;
          sclk_q <= 1'b1;
          rx_sr  <= rx_nxt;
        end
        SHIFT: if (tick) begin
          if (sclk_q) begin
            sclk_q  <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
            // Last falling edge keeps the final bit on mosi.
            if (bit_cnt != BCW'(DATA_W - 1)) begin
              tx_sr  <= tx_nxt;
              mosi_q <= tx_nxt[DATA_W-1];
            end
          end else if (bit_cnt == BCW'(DATA_W)) begin
            state <= HOLD;
          end else begin
            sclk_q <= 1'b1;
            rx_sr  <= rx_nxt;
          end
        end
        HOLD: if (tick) begin
          state     <= WRITEBACK;
          cs_n_q    <= 1'b1;
          mosi_q    <= 1'b0;
          rx_wr_q   <= 1'b1;
          done_q    <= 1'b1;
          rx_data_q <= REG_W'(rx_sr);
        end
        WRITEBACK: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sclk    = sclk_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.mosi    = mosi_q;
  assign bus.rx_data = rx_data_q;
  assign bus.rx_wr   = rx_wr_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: 12-bit build plus a 1-bit width build.
module tb_spi_xfer_ctrl;
  localparam int LIMIT = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  div = '0;
  logic [31:0] tx = '0;
  logic        miso_val = 1'b0;
  logic        lb = 1'b0;
  logic        sel = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  spi_xfer_ctrl_if #(.DIV_W(8)) b0 ();
  spi_xfer_ctrl_if #(.DIV_W(8)) b1 ();

  logic        o_sclk, o_cs_n, o_mosi, o_rx_wr, o_busy, o_done;
  logic [31:0] o_rx_data;

  assign o_sclk    = sel ? b1.sclk    : b0.sclk;
  assign o_cs_n    = sel ? b1.cs_n    : b0.cs_n;
  assign o_mosi    = sel ? b1.mosi    : b0.mosi;
  assign o_rx_wr   = sel ? b1.rx_wr   : b0.rx_wr;
  assign o_busy    = sel ? b1.busy    : b0.busy;
  assign o_done    = sel ? b1.done    : b0.done;
  assign o_rx_data = sel ? b1.rx_data : b0.rx_data;

  assign b0.start   = start & ~sel;
  assign b1.start   = start & sel;
  assign b0.div     = div;
  assign b1.div     = div;
  assign b0.tx_data = tx;
  assign b1.tx_data = tx;
  assign b0.miso    = lb ? o_mosi : miso_val;
  assign b1.miso    = lb ? o_mosi : miso_val;

  spi_xfer_ctrl #(.DATA_W(12), .DIV_W(8)) u_dut  (.clk(clk), .rst(rst), .bus(b0));
  spi_xfer_ctrl #(.DATA_W(1),  .DIV_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;

  // Observations of the latest transfer
  int          n_done, n_busy, rises, first_rise, cs_low, wr_cnt;
  logic [31:0] bits, rx_val;
  logic        per_ok, hi_ok, mosi_ok, done_ok, busy1, cs1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts a transfer from a negedge and watches it cycle by cycle (c=1 is
  // the first cycle after the accepting edge) until busy drops after done.
  task automatic xfer(input logic [31:0] t, input logic [7:0] dv,
                      input int sp_a, input int sp_b, input int mid_at,
                      input logic [7:0] dv_mid);
    int   h, c, last_rise, hi_len;
    logic prev_sclk, prev_mosi, fin;
    h = int'(dv) + 1;
    n_done = 0; n_busy = 0; rises = 0; first_rise = 0; cs_low = 0; wr_cnt = 0;
    bits = '0; rx_val = '0; per_ok = 1; hi_ok = 1; mosi_ok = 1; done_ok = 0;
    last_rise = 0; hi_len = 0; fin = 0;
    tx = t; div = dv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy1 = o_busy; cs1 = o_cs_n;
    prev_sclk = 1'b0; prev_mosi = o_mosi;
    c = 1;
    while (!fin && c <= LIMIT) begin
      start = (c == sp_a) || (c == sp_b);
      if (c == mid_at) div = dv_mid;
      if (o_busy) n_busy++;
      if (!o_cs_n) cs_low++;
      if (o_sclk && o_mosi !== prev_mosi) mosi_ok = 0;
      if (o_sclk && !prev_sclk) begin
        rises++;
        bits = {bits[30:0], o_mosi};
        if (rises == 1) first_rise = c;
        else if (c - last_rise != 2 * h) per_ok = 0;
        last_rise = c;
      end
      if (o_sclk) hi_len++;
      else if (prev_sclk) begin
        if (hi_len != h) hi_ok = 0;
        hi_len = 0;
      end
      if (o_rx_wr) begin
        wr_cnt++;
        if (n_done == 0) begin
          n_done = c; rx_val = o_rx_data; done_ok = o_done;
        end
      end
      if (n_done != 0 && !o_busy) fin = 1;
      else begin
        prev_sclk = o_sclk; prev_mosi = o_mosi;
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    if (!fin) chk("xfer_timeout", 32'(c), 32'(LIMIT));
  endtask

  task automatic expect_xfer(input string p, input int dw, input int h,
                             input logic [31:0] bits_exp, input logic [31:0] rx_exp);
    chk({p, "_rx_data"},    rx_val, rx_exp);
    chk({p, "_done_cycle"}, 32'(n_done), 32'(1 + (2 * dw + 2) * h));
    chk({p, "_busy_cycles"}, 32'(n_busy), 32'((2 * dw + 2) * h + 1));
    chk({p, "_cs_low"},     32'(cs_low), 32'((2 * dw + 2) * h));
    chk({p, "_sclk_rises"}, 32'(rises), 32'(dw));
    chk({p, "_first_rise"}, 32'(first_rise), 32'(1 + h));
    chk({p, "_mosi_bits"},  bits, bits_exp);
    chk({p, "_rx_wr_count"}, 32'(wr_cnt), 32'd1);
    chk({p, "_flags"}, {26'd0, per_ok, hi_ok, mosi_ok, done_ok, busy1, cs1}, 32'b111110);
  endtask

  initial begin
    int wr;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ctl",  {26'd0, o_sclk, o_cs_n, o_mosi, o_rx_wr, o_busy, o_done}, 32'b010000);
    chk("reset_rx",   o_rx_data, 32'h0);
    chk("reset_ctl1", {26'd0, b1.sclk, b1.cs_n, b1.mosi, b1.rx_wr, b1.busy, b1.done}, 32'b010000);
    rst = 1'b0;
    @(negedge clk);

    // Loopback, fastest divider
    lb = 1'b1;
    xfer(32'h0000_0A5C, 8'd0, -1, -1, -1, 8'd0);
    expect_xfer("loop", 12, 1, 32'h0000_0A5C, 32'h0000_0A5C);

    // Divider 3, miso high, upper tx bits ignored
    lb = 1'b0; miso_val = 1'b1;
    xfer(32'hFFFF_F123, 8'd3, -1, -1, -1, 8'd0);
    expect_xfer("div3", 12, 4, 32'h0000_0123, 32'h0000_0FFF);
    chk("idle_mosi", {31'd0, o_mosi}, 32'd0);

    // Starts while busy are dropped; a start in the first idle cycle is taken
    lb = 1'b1;
    xfer(32'h0000_0C3A, 8'd0, 5, 20, -1, 8'd0);
    expect_xfer("busy_start", 12, 1, 32'h0000_0C3A, 32'h0000_0C3A);
    xfer(32'h0000_0765, 8'd0, -1, -1, -1, 8'd0);
    expect_xfer("b2b", 12, 1, 32'h0000_0765, 32'h0000_0765);
    repeat (4) @(negedge clk);
    chk("no_queued_start", {31'd0, o_busy}, 32'd0);

    // Reset during SHIFT
    tx = 32'h0000_0333; div = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr = 0;
    repeat (9) begin
      if (o_rx_wr) wr++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ctl", {29'd0, o_cs_n, o_sclk, o_busy}, 32'b100);
    chk("rst_mid_rx",  o_rx_data, 32'h0);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (o_rx_wr || o_done) wr++;
    end
    chk("rst_no_wr", 32'(wr), 32'd0);
    xfer(32'h0000_0456, 8'd0, -1, -1, -1, 8'd0);
    expect_xfer("after_rst", 12, 1, 32'h0000_0456, 32'h0000_0456);

    // Divider change mid-transfer only affects the next transfer
    xfer(32'h0000_09F0, 8'd1, -1, -1, 10, 8'd7);
    expect_xfer("divchg", 12, 2, 32'h0000_09F0, 32'h0000_09F0);
    xfer(32'h0000_0246, 8'd7, -1, -1, -1, 8'd7);
    expect_xfer("div7", 12, 8, 32'h0000_0246, 32'h0000_0246);

    // One-bit build
    sel = 1'b1; lb = 1'b0; miso_val = 1'b1;
    @(negedge clk);
    xfer(32'h0000_0001, 8'd2, -1, -1, -1, 8'd0);
    expect_xfer("w1_div2", 1, 3, 32'h1, 32'h1);
    xfer(32'hFFFF_FFFE, 8'd0, -1, -1, -1, 8'd0);
    expect_xfer("w1_div0", 1, 1, 32'h0, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
